// File: rtl/ps2_pkg.sv
// Shared types and status-register bit positions for the PS/2 key buffer.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

   localparam int ST_NONEMPTY = 0;
   localparam int ST_FULL     = 1;
   localparam int ST_FERR     = 2;
   localparam int ST_OVF      = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a pop in the same cycle frees a slot for a push when full.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ps2_key_buffer.sv
// PS/2 keyboard receiver on the CPU clock: synchroniser, frame FSM with timeout,
// scancode FIFO, memory-mapped data/status registers and a level key interrupt.
module ps2_key_buffer
   import ps2_pkg::*;
#(
   parameter int          DEPTH     = 16,
   parameter logic [15:0] BASE_ADDR = 16'hFF00,
   parameter int          TIMEOUT   = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_dat,
   input  logic [15:0] raddr,
   input  logic        rd_strobe,
   output logic [15:0] rdata,
   input  logic [15:0] waddr,
   input  logic [15:0] wdata,
   input  logic        wenable,
   output logic        irq,
   input  logic        reset_irq
);

   localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
   localparam int          TW        = $clog2(TIMEOUT + 1);

   logic          clk_s1_q, clk_s2_q, clk_prev_q;
   logic          dat_s1_q, dat_s2_q;
   logic          fall_edge;

   ps2_state_t    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          push_d, push_q;
   logic [7:0]    push_data_q;
   logic          ferr_set;

   logic          frame_err_q, frame_err_d;
   logic          overflow_q, overflow_d;
   logic          pending_q, pending_d;
   logic [15:0]   rdata_q, rdata_d;
   logic [15:0]   status;

   logic          fifo_full, fifo_empty, fifo_pop, push_ok;
   logic [7:0]    fifo_dout;
   logic          data_rd, stat_rd, other_rd, stat_wr;
   logic          unused_wdata;

   assign unused_wdata = ^{wdata[15:4], wdata[1:0]};

   always_ff @(posedge clock) begin
      if (!reset) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_dat;
         dat_s2_q   <= dat_s1_q;
      end
   end

   assign fall_edge = !clk_s2_q && clk_prev_q;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      tmo_d     = tmo_q;
      push_d    = 1'b0;
      ferr_set  = 1'b0;
      if (fall_edge) begin
         tmo_d = '0;
         case (state_q)
            IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               parity_d = dat_s2_q;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (dat_s2_q && (^{shift_q, parity_q})) push_d   = 1'b1;
               else                                    ferr_set = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         // A stalled keyboard must not leave the receiver stuck mid-frame.
         if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d  = IDLE;
            tmo_d    = '0;
            ferr_set = 1'b1;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end else begin
         tmo_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         parity_q    <= 1'b0;
         tmo_q       <= '0;
         push_q      <= 1'b0;
         push_data_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tmo_q       <= tmo_d;
         push_q      <= push_d;
         push_data_q <= shift_q;
      end
   end

   assign data_rd  = rd_strobe && (raddr == BASE_ADDR);
   assign stat_rd  = (raddr == STAT_ADDR);
   assign other_rd = rd_strobe && !data_rd && !stat_rd;
   assign stat_wr  = wenable && (waddr == STAT_ADDR);
   assign fifo_pop = data_rd && !fifo_empty;
   assign push_ok  = push_q && (!fifo_full || fifo_pop);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_q),
      .din   (push_data_q),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      status              = 16'h0000;
      status[ST_NONEMPTY] = !fifo_empty;
      status[ST_FULL]     = fifo_full;
      status[ST_FERR]     = frame_err_q;
      status[ST_OVF]      = overflow_q;
   end

   // Sticky flags and the irq pending bit: a set in the same cycle beats a clear.
   always_comb begin
      rdata_d     = rdata_q;
      overflow_d  = overflow_q;
      frame_err_d = frame_err_q;
      pending_d   = pending_q;
      if (data_rd)       rdata_d = fifo_empty ? 16'h0000 : {8'h00, fifo_dout};
      else if (stat_rd)  rdata_d = status;
      else if (other_rd) rdata_d = 16'h0000;
      if (stat_wr && wdata[3]) overflow_d  = 1'b0;
      if (stat_wr && wdata[2]) frame_err_d = 1'b0;
      if (push_q && !push_ok)  overflow_d  = 1'b1;
      if (ferr_set)            frame_err_d = 1'b1;
      if (reset_irq)           pending_d   = 1'b0;
      if (push_ok)             pending_d   = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rdata_q     <= 16'h0000;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         rdata_q     <= rdata_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
         pending_q   <= pending_d;
      end
   end

   assign rdata = rdata_q;
   assign irq   = pending_q;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Self-checking bench: PS/2 frames driven on the pins, CPU reads/writes checked
// against a queue-based model of the key buffer.
module tb_ps2_key_buffer;

   localparam logic [15:0] BASE = 16'hFF00;
   localparam logic [15:0] STAT = 16'hFF01;
   localparam int          HALF = 10;
   localparam int          DEP  = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_dat = 1'b1;
   logic [15:0] raddr = 16'h0000;
   logic        rd_strobe = 1'b0;
   logic [15:0] rdata;
   logic [15:0] waddr = 16'h0000;
   logic [15:0] wdata = 16'h0000;
   logic        wenable = 1'b0;
   logic        irq;
   logic        reset_irq = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [7:0] q[$];
   logic       m_ovf = 1'b0;
   logic       m_ferr = 1'b0;
   logic       m_irq = 1'b0;

   ps2_key_buffer #(
      .DEPTH     (DEP),
      .BASE_ADDR (BASE),
      .TIMEOUT   (1000)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_dat   (ps2_dat),
      .raddr     (raddr),
      .rd_strobe (rd_strobe),
      .rdata     (rdata),
      .waddr     (waddr),
      .wdata     (wdata),
      .wenable   (wenable),
      .irq       (irq),
      .reset_irq (reset_irq)
   );

   always #5 clock = ~clock;

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit perr, input bit serr);
      logic p;
      p = ~(^b) ^ perr;
      return {~serr, p, b, 1'b0};
   endfunction

   function automatic logic [15:0] exp_status();
      return {12'h000, m_ovf, m_ferr, (q.size() == DEP), (q.size() != 0)};
   endfunction

   function automatic logic [15:0] exp_pop();
      if (q.size() == 0) return 16'h0000;
      return {8'h00, q.pop_front()};
   endfunction

   task automatic ps2_send(input logic [10:0] fr, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = fr[i];
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
      repeat (HALF) @(negedge clock);
   endtask

   task automatic send_and_model(input logic [7:0] b, input bit perr, input bit serr);
      ps2_send(mk_frame(b, perr, serr), 11);
      if (!perr && !serr) begin
         if (q.size() < DEP) begin
            q.push_back(b);
            m_irq = 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
      end else begin
         m_ferr = 1'b1;
      end
      $display("frame %h perr=%0d serr=%0d queued=%0d", b, perr, serr, q.size());
   endtask

   task automatic cpu_read(input logic [15:0] addr, input logic strobe, output logic [15:0] val);
      @(negedge clock);
      raddr     = addr;
      rd_strobe = strobe;
      @(negedge clock);
      rd_strobe = 1'b0;
      raddr     = 16'h0000;
      val       = rdata;
      $display("read  addr=%h strobe=%0d data=%h", addr, strobe, val);
   endtask

   task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
      @(negedge clock);
      waddr   = addr;
      wdata   = data;
      wenable = 1'b1;
      @(negedge clock);
      wenable = 1'b0;
      $display("write addr=%h data=%h", addr, data);
      if (addr == STAT) begin
         if (data[3]) m_ovf = 1'b0;
         if (data[2]) m_ferr = 1'b0;
      end
   endtask

   task automatic pulse_reset_irq();
      @(negedge clock);
      reset_irq = 1'b1;
      @(negedge clock);
      reset_irq = 1'b0;
      m_irq = 1'b0;
      $display("reset_irq pulse");
   endtask

   task automatic test_reset();
      logic [15:0] v;
      reset = 1'b0;
      repeat (5) @(negedge clock);
      checks++;
      if (rdata !== 16'h0000) begin
         failures++;
         $display("FAIL reset_rdata: got %h expected 0000", rdata);
      end
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
      reset = 1'b1;
      cpu_read(STAT, 1'b0, v);
      checks++;
      if (v !== 16'h0000) begin
         failures++;
         $display("FAIL reset_status: got %h expected 0000", v);
      end
   endtask

   task automatic test_single();
      logic [15:0] v;
      send_and_model(8'h1C, 1'b0, 1'b0);
      cpu_read(STAT, 1'b0, v);
      checks++;
      if (v !== 16'h0001) begin
         failures++;
         $display("FAIL single_status: got %h expected 0001", v);
      end
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL single_irq: got %b expected 1", irq);
      end
      cpu_read(BASE, 1'b1, v);
      void'(exp_pop());
      checks++;
      if (v !== 16'h001C) begin
         failures++;
         $display("FAIL single_data: got %h expected 001C", v);
      end
      cpu_read(STAT, 1'b0, v);
      checks++;
      if (v !== 16'h0000) begin
         failures++;
         $display("FAIL single_status_after: got %h expected 0000", v);
      end
      pulse_reset_irq();
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL lone_reset_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] v;
      logic [15:0] e;
      for (int i = 1; i <= 17; i++) send_and_model(8'(i), 1'b0, 1'b0);
      cpu_read(STAT, 1'b0, v);
      checks++;
      if (v !== 16'h000B || v !== exp_status()) begin
         failures++;
         $display("FAIL overflow_status: got %h expected 000B", v);
      end
      for (int i = 1; i <= 17; i++) begin
         cpu_read(BASE, 1'b1, v);
         e = exp_pop();
         checks++;
         if (v !== e) begin
            failures++;
            $display("FAIL overflow_read%0d: got %h expected %h", i, v, e);
         end
      end
      cpu_write(STAT, 16'h0008);
      cpu_read(STAT, 1'b0, v);
      checks++;
      if (v !== 16'h0000) begin
         failures++;
         $display("FAIL overflow_clear: got %h expected 0000", v);
      end
   endtask

   task automatic test_parity_err();
      logic [15:0] v;
      send_and_model(8'h1C, 1'b1, 1'b0);
      cpu_read(STAT, 1'b0, v);
      checks++;
      if (v !== 16'h0004) begin
         failures++;
         $display("FAIL parity_status: got %h expected 0004", v);
      end
      cpu_write(STAT, 16'h0004);
      cpu_read(STAT, 1'b0, v);
      checks++;
      if (v !== 16'h0000) begin
         failures++;
         $display("FAIL parity_clear: got %h expected 0000", v);
      end
   endtask

   task automatic test_timeout();
      logic [15:0] v;
      logic [15:0] e;
      ps2_send(mk_frame(8'hA5, 1'b0, 1'b0), 4);
      repeat (1100) @(negedge clock);
      m_ferr = 1'b1;
      $display("partial frame abandoned");
      send_and_model(8'h5A, 1'b0, 1'b0);
      cpu_read(STAT, 1'b0, v);
      checks++;
      if (v !== 16'h0005) begin
         failures++;
         $display("FAIL timeout_status: got %h expected 0005", v);
      end
      for (int i = 0; i < 2; i++) begin
         cpu_read(BASE, 1'b1, v);
         e = exp_pop();
         checks++;
         if (v !== e) begin
            failures++;
            $display("FAIL timeout_read%0d: got %h expected %h", i, v, e);
         end
      end
      cpu_write(STAT, 16'h000C);
   endtask

   task automatic test_irq_coincident();
      int hi;
      logic [15:0] v;
      hi = 0;
      pulse_reset_irq();
      @(negedge clock);
      reset_irq = 1'b1;
      fork
         send_and_model(8'h33, 1'b0, 1'b0);
         begin
            for (int i = 0; i < 22 * HALF + 40; i++) begin
               @(negedge clock);
               if (irq === 1'b1) hi++;
            end
         end
      join
      reset_irq = 1'b0;
      m_irq = 1'b0;
      checks++;
      if (hi !== 1) begin
         failures++;
         $display("FAIL irq_coincident_cycles: got %0d expected 1", hi);
      end
      @(negedge clock);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_after_ack: got %b expected 0", irq);
      end
      cpu_read(BASE, 1'b1, v);
      checks++;
      if (v !== exp_pop()) begin
         failures++;
         $display("FAIL irq_coincident_data: got %h expected 0033", v);
      end
   endtask

   task automatic test_mid_reset();
      logic [15:0] v;
      logic [15:0] e;
      send_and_model(8'h10, 1'b0, 1'b0);
      ps2_send(mk_frame(8'h77, 1'b0, 1'b0), 5);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      q.delete();
      m_ovf = 1'b0;
      m_ferr = 1'b0;
      m_irq = 1'b0;
      $display("mid-frame reset");
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL midreset_irq: got %b expected 0", irq);
      end
      send_and_model(8'h29, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cpu_read(BASE, 1'b1, v);
         e = exp_pop();
         checks++;
         if (v !== e) begin
            failures++;
            $display("FAIL midreset_read%0d: got %h expected %h", i, v, e);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] v;
      logic [15:0] e;
      int r;
      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 7);
         send_and_model(8'($urandom), (r == 0), (r == 1));
         checks++;
         if (irq !== m_irq) begin
            failures++;
            $display("FAIL rand_irq%0d: got %b expected %b", n, irq, m_irq);
         end
         if ($urandom_range(0, 2) == 0) begin
            for (int k = 0; k < $urandom_range(1, 3); k++) begin
               cpu_read(BASE, 1'b1, v);
               e = exp_pop();
               checks++;
               if (v !== e) begin
                  failures++;
                  $display("FAIL rand_read%0d: got %h expected %h", n, v, e);
               end
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            cpu_read(STAT, 1'b0, v);
            e = exp_status();
            checks++;
            if (v !== e) begin
               failures++;
               $display("FAIL rand_status%0d: got %h expected %h", n, v, e);
            end
         end
         if ($urandom_range(0, 4) == 0) cpu_write(STAT, 16'($urandom_range(0, 15)) << 0);
         if ($urandom_range(0, 4) == 0) pulse_reset_irq();
      end
      while (q.size() > 0 || v !== 16'h0000) begin
         cpu_read(BASE, 1'b1, v);
         e = exp_pop();
         checks++;
         if (v !== e) begin
            failures++;
            $display("FAIL rand_drain: got %h expected %h", v, e);
            break;
         end
      end
      cpu_read(STAT, 1'b0, v);
      e = exp_status();
      checks++;
      if (v !== e) begin
         failures++;
         $display("FAIL rand_final_status: got %h expected %h", v, e);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_parity_err();
      test_timeout();
      test_irq_coincident();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
